gs_div_issue: RTL and testbench

Request-side initiator for the Goldschmidt divider `gs_div`. It accepts tagged Q32.40 operand pairs over a valid/ready stream and queues them in a small FIFO. It issues them one at a time to a single `gs_div` instance by driving its `N`/`D`/`rst` pins and waiting for `done`, then returns the captured quotient over a valid/ready response stream. It also screens out divide-by-zero, which `gs_div` does not handle.

---
 rtl/gs_div_pkg.sv | 19 +
 rtl/gs_div_req_fifo.sv | 44 ++++
 rtl/gs_div_issue.sv | 153 +++++++++++++++
 tb/tb_gs_div_issue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gs_div_pkg.sv
// gs_div_pkg: shared constants and FSM state type for the Goldschmidt
// divider request issuer.
//   I_BITS/F_BITS/T_BITS : Q32.40 operand format
//   Q_ONE                : 1.0 in that format
//   gs_state_e           : issuer FSM states
package gs_div_pkg;
  localparam int I_BITS = 32;
  localparam int F_BITS = 40;
  localparam int T_BITS = I_BITS + F_BITS;

  localparam logic [T_BITS-1:0] Q_ONE = T_BITS'(1) << F_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } gs_state_e;
endpackage

// File: rtl/gs_div_req_fifo.sv
// gs_div_req_fifo: synchronous request FIFO with extra-MSB pointers.
//   clk, rst          : clock, async active-high reset (empties the FIFO)
//   push_i, wdata_i   : write strobe/data (ignored when full)
//   pop_i             : read strobe (ignored when empty)
//   rdata_o           : head entry (combinational from the array)
//   full_o, empty_o   : decoded from the pointer registers
module gs_div_req_fifo #(
  parameter int W     = 148,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;

  // Extra MSB distinguishes full from empty when the low bits match.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign rdata_o = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wptr_q <= wptr_q + 1'b1;
      if (pop_i  && !empty_o) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset; validity is carried by the pointers.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/gs_div_issue.sv
// gs_div_issue: queues tagged Q32.40 divide requests and issues them one at
// a time to an external gs_div, returning the quotient with its tag.
// Divide-by-zero is screened here (all-ones quotient, rsp_err=1).
//   req_*  : valid/ready request stream (n, d, tag)
//   rsp_*  : valid/ready response stream (q, tag, err), registered
//   div_*  : gs_div pins (N, D, rst out; Q, done in)
// Optional macro GS_DIV_TIMEOUT_EN: abort a WAIT after TIMEOUT cycles with
// rsp_q=0, rsp_err=1.
module gs_div_issue #(
  parameter int T_BITS   = 72,
  parameter int TAG_BITS = 4,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [T_BITS-1:0]   req_n,
  input  logic [T_BITS-1:0]   req_d,
  input  logic [TAG_BITS-1:0] req_tag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [T_BITS-1:0]   rsp_q,
  output logic [TAG_BITS-1:0] rsp_tag,
  output logic                rsp_err,
  output logic [T_BITS-1:0]   div_n,
  output logic [T_BITS-1:0]   div_d,
  output logic                div_rst,
  input  logic [T_BITS-1:0]   div_q,
  input  logic                div_done
);
  import gs_div_pkg::*;

  localparam int W = 2*T_BITS + TAG_BITS;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH-1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be >= 1");
  end

  gs_state_e           state_q;
  logic [T_BITS-1:0]   div_n_q, div_d_q, rsp_q_q;
  logic [TAG_BITS-1:0] rsp_tag_q;
  logic                rsp_valid_q, rsp_err_q, div_rst_q;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [W-1:0]        fifo_rdata;
  logic [T_BITS-1:0]   head_n, head_d;
  logic [TAG_BITS-1:0] head_tag;

  assign req_ready = !fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign head_tag  = fifo_rdata[W-1 -: TAG_BITS];
  assign head_n    = fifo_rdata[2*T_BITS-1 -: T_BITS];
  assign head_d    = fifo_rdata[T_BITS-1:0];

  gs_div_req_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid),
    .wdata_i ({req_tag, req_n, req_d}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef GS_DIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
`endif

  // The zero-divisor screen runs on the registered divisor in LOAD, so a
  // zero divisor answers one cycle after the pop while div_rst stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_n_q     <= '0;
      div_d_q     <= '0;
      div_rst_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q_q     <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
`ifdef GS_DIV_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            div_n_q   <= head_n;
            div_d_q   <= head_d;
            rsp_tag_q <= head_tag;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (div_d_q == '0) begin
            rsp_q_q     <= '1;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            div_rst_q <= 1'b0;
            state_q   <= ST_WAIT;
`ifdef GS_DIV_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (div_done) begin
            rsp_q_q     <= div_q;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            div_rst_q   <= 1'b1;
            state_q     <= ST_RESP;
          end
`ifdef GS_DIV_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_q_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            div_rst_q   <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;
  assign div_n     = div_n_q;
  assign div_d     = div_d_q;
  assign div_rst   = div_rst_q;
endmodule

// File: tb/tb_gs_div_issue.sv
// Bench for gs_div_issue with a behavioural gs_div stand-in and a
// scoreboard/monitor pair checking every response in order.
module tb_gs_div_issue;
  localparam int T = 72;
  localparam int TG = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [T-1:0]  req_n, req_d, rsp_q, div_n, div_d, div_q;
  logic [TG-1:0] req_tag, rsp_tag;
  logic          div_rst, div_done;

  always #5 clk = ~clk;

  gs_div_issue #(.T_BITS(T), .TAG_BITS(TG), .DEPTH(4), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .req_d(req_d), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .div_n(div_n), .div_d(div_d), .div_rst(div_rst),
    .div_q(div_q), .div_done(div_done)
  );

  // Divider stand-in: N==D gives raw 1 and N<D gives 0, both done in the
  // first running cycle; otherwise the Q-format quotient after 10 cycles.
  logic          stuck;
  int            scnt;
  logic [111:0]  wide_q;
  always @(posedge clk) scnt <= div_rst ? 0 : scnt + 1;
  assign wide_q   = {div_n, 40'd0} / {40'd0, (div_d == '0 ? 72'd1 : div_d)};
  assign div_q    = (div_n == div_d) ? 72'd1 : (div_n < div_d) ? 72'd0 : wide_q[T-1:0];
  assign div_done = !div_rst && !stuck && ((div_n <= div_d) || scnt == 9);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [T-1:0]  q;
    logic [TG-1:0] tag;
    logic          err;
    bit            tol;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [T-1:0] act, input logic [T-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [T-1:0] q, input logic [TG-1:0] tag,
                            input logic err, input bit tol);
    exp_t e;
    e.q = q; e.tag = tag; e.err = err; e.tol = tol;
    sb.push_back(e);
  endtask

  // Monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got tag %0d q %h with none expected", rsp_tag, rsp_q);
      end else begin
        exp_t e;
        logic [T-1:0] diff;
        e = sb.pop_front();
        diff = (rsp_q > e.q) ? rsp_q - e.q : e.q - rsp_q;
        checks++;
        if (rsp_tag !== e.tag || rsp_err !== e.err ||
            (e.tol ? (diff > (72'd1 << 20)) : (rsp_q !== e.q))) begin
          errors++;
          $display("FAIL rsp: got q %h tag %0d err %b expected q %h tag %0d err %b",
                   rsp_q, rsp_tag, rsp_err, e.q, e.tag, e.err);
        end
      end
    end
  end

  int tpush;

  // Called and returning at a negedge; bounded wait for req_ready.
  task automatic push(input logic [T-1:0] n, input logic [T-1:0] d, input logic [TG-1:0] tag);
    int k = 0;
    req_valid = 1'b1; req_n = n; req_d = d; req_tag = tag;
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    if (k == 100) begin
      checks++; errors++;
      $display("FAIL push_timeout: req_ready stuck at %b, required 1", req_ready);
    end
    tpush = cyc;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin @(negedge clk); k++; end
    if (k == 300) begin
      checks++; errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Returns cycles from push to first rsp_valid; rst_low flags any div_rst=0.
  task automatic wait_rsp(input int bound, output int lat, output bit rst_low);
    int k = 0;
    rst_low = 1'b0;
    while (!rsp_valid && k < bound) begin
      if (!div_rst) rst_low = 1'b1;
      @(negedge clk); k++;
    end
    lat = rsp_valid ? (cyc - tpush) : -1;
  endtask

  int  lat;
  bit  rlow;
  bit  saw_valid;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_n = '0; req_d = '0; req_tag = '0;
    rsp_ready = 1'b1; stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 72'(req_ready), 72'd1);
    chk("rst_rsp_valid", 72'(rsp_valid), 72'd0);
    chk("rst_rsp_q",     rsp_q, 72'd0);
    chk("rst_rsp_tag",   72'(rsp_tag), 72'd0);
    chk("rst_rsp_err",   72'(rsp_err), 72'd0);
    chk("rst_div_n",     div_n, 72'd0);
    chk("rst_div_d",     div_d, 72'd0);
    chk("rst_div_rst",   72'(div_rst), 72'd1);
    rst = 1'b0;
    @(negedge clk);

    // 6.0 / 2.0 -> 3.0
    expect_rsp(72'd3 << 40, 4'd3, 1'b0, 1'b1);
    push(72'd6 << 40, 72'd2 << 40, 4'd3);
    drain();

    // N==D: raw 1, four cycles after push
    expect_rsp(72'd1, 4'd5, 1'b0, 1'b0);
    push(72'd5 << 40, 72'd5 << 40, 4'd5);
    wait_rsp(50, lat, rlow);
    chk("lat_trivial", 72'(lat), 72'd4);
    drain();

    // tiny N<D: raw 0
    expect_rsp(72'd0, 4'd6, 1'b0, 1'b0);
    push(72'h10, 72'h20, 4'd6);
    drain();

    // divide by zero: all ones, err, latency 3, divider never released
    expect_rsp('1, 4'd9, 1'b1, 1'b0);
    push(72'd7 << 40, 72'd0, 4'd9);
    wait_rsp(50, lat, rlow);
    chk("lat_dbz", 72'(lat), 72'd3);
    chk("dbz_div_rst_low", 72'(rlow), 72'd0);
    drain();
    chk("dbz_div_rst_after", 72'(div_rst), 72'd1);

    // back-pressure: one in flight plus four queued fills the FIFO
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_rsp(72'd1, 4'(10 + i), 1'b0, 1'b0);
      push(72'd4 << 40, 72'd4 << 40, 4'(10 + i));
    end
    repeat (2) @(negedge clk);
    chk("full_req_ready", 72'(req_ready), 72'd0);
    chk("full_rsp_tag", 72'(rsp_tag), 72'd10);
    rsp_ready = 1'b1;
    drain();
    repeat (20) @(negedge clk);
    chk("after_fill_req_ready", 72'(req_ready), 72'd1);

    // divider never finishes
    stuck = 1'b1;
`ifdef GS_DIV_TIMEOUT_EN
    expect_rsp(72'd0, 4'd2, 1'b1, 1'b0);
    push(72'd9 << 40, 72'd3 << 40, 4'd2);
    wait_rsp(100, lat, rlow);
    chk("lat_timeout", 72'(lat), 72'd35);
    drain();
    push(72'd9 << 40, 72'd3 << 40, 4'd4);
    push(72'd8 << 40, 72'd3 << 40, 4'd7);
    push(72'd7 << 40, 72'd3 << 40, 4'd8);
`else
    push(72'd9 << 40, 72'd3 << 40, 4'd2);
    push(72'd8 << 40, 72'd3 << 40, 4'd4);
    push(72'd7 << 40, 72'd3 << 40, 4'd7);
    saw_valid = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid) saw_valid = 1'b1;
    end
    chk("no_timeout_rsp_valid", 72'(saw_valid), 72'd0);
`endif

    // reset while waiting with two queued
    begin
      int k = 0;
      while (div_rst && k < 50) begin @(negedge clk); k++; end
      chk("in_wait_div_rst", 72'(div_rst), 72'd0);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_div_rst", 72'(div_rst), 72'd1);
    chk("mid_rst_rsp_valid", 72'(rsp_valid), 72'd0);
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_req_ready", 72'(req_ready), 72'd1);
    chk("post_rst_rsp_valid", 72'(rsp_valid), 72'd0);
    chk("post_rst_div_n", div_n, 72'd0);
    chk("post_rst_div_rst", 72'(div_rst), 72'd1);
    chk("post_rst_sb_empty", 72'(sb.size()), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
